lives_display: RTL

Reader-side consumer of the 24x24, 4-bit-per-pixel life-icon sprite ROM. Tracks the player's remaining lives, converts the VGA pixel stream (DrawX/DrawY) into ROM read addresses for a horizontal row of life icons, and aligns the ROM's registered read data back to the pixel stream. It emits a palette index plus a valid flag to the colour mapper. It also blinks the icon of a just-lost life for a programmable number of frames.

---
 rtl/lives_display.sv | 137 +++++++++++++
 1 files changed

// File: rtl/lives_display.sv
// Lives counter plus a row of life-icon sprites fed from a registered 24x24 ROM; pixel path latency 3 edges, never stalls.
// Optional LIVES_BLINK_EN: blinks the icon of a just-lost life for BLINK_FRAMES frames.
module lives_display #(
  parameter int          MAX_LIVES    = 5,
  parameter int          START_LIVES  = 3,
  parameter logic [9:0]  X0           = 10'd16,
  parameter logic [9:0]  Y0           = 10'd448,
  parameter int          SPACING      = 28,
  parameter logic [3:0]  TRANSPARENT  = 4'h0,
  parameter int          BLINK_FRAMES = 32
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_start,
  input  logic       new_game,
  input  logic       life_lost,
  input  logic       life_gained,
  input  logic       pixel_en,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] rom_address,
  input  logic [3:0] rom_data,
  output logic       pix_valid,
  output logic [3:0] pix_index,
  output logic [2:0] lives,
  output logic       game_over
);

  localparam logic [2:0] MAX_L   = 3'(MAX_LIVES);
  localparam logic [2:0] START_L = 3'(START_LIVES);

  logic [2:0] lives_q, lives_d;
  logic       game_over_q;
  logic       lost_eff;
  logic       blink_vis;

  always_comb begin
    lives_d  = lives_q;
    lost_eff = 1'b0;
    if (new_game) begin
      lives_d = START_L;
    end else if (life_lost && life_gained) begin
      lives_d = lives_q;
    end else if (life_lost) begin
      if (lives_q != 3'd0) begin
        lives_d  = lives_q - 3'd1;
        lost_eff = 1'b1;
      end
    end else if (life_gained) begin
      if (lives_q < MAX_L) lives_d = lives_q + 3'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lives_q     <= START_L;
      game_over_q <= 1'b0;
    end else begin
      lives_q     <= lives_d;
      game_over_q <= (lives_d == 3'd0);
    end
  end

`ifdef LIVES_BLINK_EN
  logic [7:0] blink_q, blink_d;

  // A fresh loss restarts the blink; the blinking slot is always the one at index lives.
  always_comb begin
    blink_d = blink_q;
    if (new_game)                           blink_d = 8'd0;
    else if (lost_eff)                      blink_d = 8'(BLINK_FRAMES);
    else if (frame_start && blink_q != 8'd0) blink_d = blink_q - 8'd1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) blink_q <= 8'd0;
    else          blink_q <= blink_d;
  end

  assign blink_vis = (blink_q != 8'd0) && blink_q[3];
`else
  logic unused_blink;
  assign unused_blink = frame_start ^ lost_eff;
  assign blink_vis    = 1'b0;
`endif

  function automatic logic [9:0] slot_x(input int k);
    return X0 + 10'(k * SPACING);
  endfunction

  logic       geo_hit, draw_hit, y_in;
  logic [9:0] x_off, y_off, addr_d;

  always_comb begin
    geo_hit  = 1'b0;
    draw_hit = 1'b0;
    x_off    = 10'd0;
    y_in     = (DrawY >= Y0) && (DrawY < Y0 + 10'd24);
    y_off    = DrawY - Y0;
    for (int k = 0; k < MAX_LIVES; k++) begin
      if (y_in && DrawX >= slot_x(k) && DrawX < slot_x(k) + 10'd24) begin
        geo_hit = 1'b1;
        x_off   = DrawX - slot_x(k);
        if (3'(k) < lives_q || (3'(k) == lives_q && blink_vis)) draw_hit = 1'b1;
      end
    end
    addr_d = y_off * 10'd24 + x_off;
  end

  logic [9:0] addr_q;
  logic       hit_q, hit_dly_q;
  logic       pix_valid_q;
  logic [3:0] pix_index_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q      <= 10'd0;
      hit_q       <= 1'b0;
      hit_dly_q   <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_index_q <= 4'd0;
    end else begin
      if (pixel_en && geo_hit) addr_q <= addr_d;
      hit_q       <= pixel_en && draw_hit;
      hit_dly_q   <= hit_q;
      pix_valid_q <= hit_dly_q && (rom_data != TRANSPARENT);
      pix_index_q <= (hit_dly_q && (rom_data != TRANSPARENT)) ? rom_data : 4'd0;
    end
  end

  assign rom_address = addr_q;
  assign pix_valid   = pix_valid_q;
  assign pix_index   = pix_index_q;
  assign lives       = lives_q;
  assign game_over   = game_over_q;

endmodule
